// File: rtl/svm_pkg.sv
// svm_pkg: level-code types, per-phase level bundle and sequencer state encoding for svm_seq.
// Latency: none (types and a combinational helper only).
// Backpressure: none.
package svm_pkg;

  localparam int LEVEL_W = 5;

  typedef logic [LEVEL_W-1:0] level_t;

  typedef struct packed {
    level_t c;
    level_t b;
    level_t a;
  } phase_levels_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } seq_state_e;

  // True when every phase code is within the converter's legal level range.
  function automatic logic levels_ok(input phase_levels_t v, input level_t max_level);
    return (v.a <= max_level) && (v.b <= max_level) && (v.c <= max_level);
  endfunction

endpackage

// File: rtl/svm_step_limit.sv
// svm_step_limit: one phase's ramp limiter, output moves at most one level code per cycle.
// Latency: 1 cycle per level step toward the target (registered output).
// Backpressure: none; the target may change every cycle and the ramp re-aims immediately.
`ifdef SVM_SEQ_STEP_LIMIT_EN
module svm_step_limit
  import svm_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  level_t i_target,
  output level_t o_level
);

  level_t level_q;
  level_t level_d;

  // Step one code toward the target, hold when already there.
  always_comb begin
    level_d = level_q;
    if (i_target > level_q) begin
      level_d = level_q + 1'b1;
    end else if (i_target < level_q) begin
      level_d = level_q - 1'b1;
    end
  end

  // Output level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign o_level = level_q;

endmodule
`endif

// File: rtl/svm_seq.sv
// svm_seq: plays one validated 3-vector descriptor per period as a centre-aligned up/down sequence (SVM_SEQ_STEP_LIMIT_EN adds per-phase ramp limiting).
// Latency: level outputs 1 cycle after the counter value; o_sync on the first UP cycle; o_err 1 cycle after a rejected transfer.
// Backpressure: s_ready low while the shadow descriptor is waiting for the next period start.
module svm_seq
  import svm_pkg::*;
#(
  parameter int CNT_WIDTH = 16,
  parameter int PERIOD    = 5000,
  parameter int MAX_LEVEL = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_enable,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [3*LEVEL_W-1:0] s_vec0,
  input  logic [3*LEVEL_W-1:0] s_vec1,
  input  logic [3*LEVEL_W-1:0] s_vec2,
  input  logic [CNT_WIDTH-1:0] s_t1,
  input  logic [CNT_WIDTH-1:0] s_t2,
  output logic [LEVEL_W-1:0]   o_level_a,
  output logic [LEVEL_W-1:0]   o_level_b,
  output logic [LEVEL_W-1:0]   o_level_c,
  output logic                 o_sync,
  output logic                 o_err
);

  localparam int                   HALF    = PERIOD / 2;
  localparam logic [CNT_WIDTH-1:0] HALF_C  = CNT_WIDTH'(HALF);
  localparam logic [CNT_WIDTH-1:0] HALF_M1 = CNT_WIDTH'(HALF - 1);
  localparam logic [CNT_WIDTH:0]   HALF_W  = (CNT_WIDTH+1)'(HALF);
  localparam level_t               MAX_L   = level_t'(MAX_LEVEL);

  // Thresholds are kept instead of dwells: th1 = t0, th2 = t0 + t1 = HALF - t2.
  typedef struct packed {
    phase_levels_t          vec0;
    phase_levels_t          vec1;
    phase_levels_t          vec2;
    logic [CNT_WIDTH-1:0]   th1;
    logic [CNT_WIDTH-1:0]   th2;
  } seq_desc_t;

  seq_state_e           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  seq_desc_t            shadow_q, shadow_d;
  seq_desc_t            active_q, active_d;
  logic                 shadow_full_q, shadow_full_d;
  logic                 active_valid_q, active_valid_d;
  logic                 sync_q, sync_d;
  logic                 err_q, err_d;

  logic                 period_start;
  logic                 xfer;
  logic                 desc_ok;
  logic [CNT_WIDTH:0]   dwell_sum;
  phase_levels_t        in_vec0, in_vec1, in_vec2;
  phase_levels_t        seg_lvl, target;

  assign s_ready = !shadow_full_q;

  // Descriptor intake: handshake and validation; the dwell sum carries one extra bit so it cannot wrap.
  always_comb begin
    in_vec0   = phase_levels_t'(s_vec0);
    in_vec1   = phase_levels_t'(s_vec1);
    in_vec2   = phase_levels_t'(s_vec2);
    dwell_sum = {1'b0, s_t1} + {1'b0, s_t2};
    desc_ok   = (dwell_sum <= HALF_W) && levels_ok(in_vec0, MAX_L) &&
                levels_ok(in_vec1, MAX_L) && levels_ok(in_vec2, MAX_L);
    xfer      = s_valid && s_ready;
  end

  // Sequencer FSM: up-count then down-count the half period; enable low forces IDLE at once.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    period_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_enable && (shadow_full_q || active_valid_q)) begin
          state_d      = UP;
          cnt_d        = '0;
          period_start = 1'b1;
        end
      end
      UP: begin
        if (cnt_q == HALF_M1) begin
          state_d = DOWN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DOWN: begin
        if (cnt_q == '0) begin
          state_d      = UP;
          period_start = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    if (!i_enable) begin
      state_d      = IDLE;
      cnt_d        = '0;
      period_start = 1'b0;
    end
  end

  // Double buffer: promote the shadow only at a period start, capture new descriptors into the shadow.
  always_comb begin
    shadow_d       = shadow_q;
    shadow_full_d  = shadow_full_q;
    active_d       = active_q;
    active_valid_d = active_valid_q;
    sync_d         = period_start;
    err_d          = xfer && !desc_ok;
    if (period_start && shadow_full_q) begin
      active_d       = shadow_q;
      active_valid_d = 1'b1;
      shadow_full_d  = 1'b0;
    end
    if (xfer && desc_ok) begin
      shadow_d.vec0 = in_vec0;
      shadow_d.vec1 = in_vec1;
      shadow_d.vec2 = in_vec2;
      shadow_d.th1  = HALF_C - s_t1 - s_t2;
      shadow_d.th2  = HALF_C - s_t2;
      shadow_full_d = 1'b1;
    end
  end

  // Segment select; the down half reuses the same thresholds on a falling count, which mirrors the up half.
  always_comb begin
    seg_lvl = active_q.vec2;
    if (cnt_q < active_q.th1) begin
      seg_lvl = active_q.vec0;
    end else if (cnt_q < active_q.th2) begin
      seg_lvl = active_q.vec1;
    end
    target = '0;
    if (i_enable && (state_q != IDLE)) begin
      target = seg_lvl;
    end
  end

  // Control and descriptor state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shadow_q       <= '0;
      active_q       <= '0;
      shadow_full_q  <= 1'b0;
      active_valid_q <= 1'b0;
      sync_q         <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shadow_q       <= shadow_d;
      active_q       <= active_d;
      shadow_full_q  <= shadow_full_d;
      active_valid_q <= active_valid_d;
      sync_q         <= sync_d;
      err_q          <= err_d;
    end
  end

  assign o_sync = sync_q;
  assign o_err  = err_q;

`ifdef SVM_SEQ_STEP_LIMIT_EN
  svm_step_limit u_step_a (.clk(clk), .rst_n(rst_n), .i_target(target.a), .o_level(o_level_a));
  svm_step_limit u_step_b (.clk(clk), .rst_n(rst_n), .i_target(target.b), .o_level(o_level_b));
  svm_step_limit u_step_c (.clk(clk), .rst_n(rst_n), .i_target(target.c), .o_level(o_level_c));
`else
  phase_levels_t level_q, level_d;

  // Outputs follow the target directly, one cycle behind the counter.
  always_comb begin
    level_d = target;
  end

  // Output level register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  assign o_level_a = level_q.a;
  assign o_level_b = level_q.b;
  assign o_level_c = level_q.c;
`endif

endmodule

// File: tb/tb_svm_seq.sv
// tb_svm_seq: randomized and directed checks of svm_seq against a period-level reference model.
// Latency: model expects levels one cycle behind the count, o_sync on the first UP cycle.
// Backpressure: model tracks shadow occupancy and expects s_ready low while it is full.
module tb_svm_seq;

  localparam int HALF = 10;
  localparam int PER  = 20;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic        i_enable = 1'b0;
  logic        s_valid  = 1'b0;
  logic        s_ready;
  logic [14:0] s_vec0   = '0;
  logic [14:0] s_vec1   = '0;
  logic [14:0] s_vec2   = '0;
  logic [15:0] s_t1     = '0;
  logic [15:0] s_t2     = '0;
  logic [4:0]  o_level_a, o_level_b, o_level_c;
  logic        o_sync, o_err;

  typedef struct {
    logic [14:0] v0;
    logic [14:0] v1;
    logic [14:0] v2;
    int          t1;
    int          t2;
  } desc_t;

  int          checks = 0;
  int          passed = 0;
  desc_t       mdl_active;
  desc_t       mdl_shadow;
  bit          mdl_full = 1'b0;
  logic [14:0] mdl_out  = '0;

  svm_seq #(.CNT_WIDTH(16), .PERIOD(PER), .MAX_LEVEL(4)) dut (
    .clk(clk), .rst_n(rst_n), .i_enable(i_enable),
    .s_valid(s_valid), .s_ready(s_ready),
    .s_vec0(s_vec0), .s_vec1(s_vec1), .s_vec2(s_vec2),
    .s_t1(s_t1), .s_t2(s_t2),
    .o_level_a(o_level_a), .o_level_b(o_level_b), .o_level_c(o_level_c),
    .o_sync(o_sync), .o_err(o_err)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [14:0] lv(input int c, input int b, input int a);
    return {5'(c), 5'(b), 5'(a)};
  endfunction

  function automatic desc_t mk(input logic [14:0] v0, input logic [14:0] v1,
                               input logic [14:0] v2, input int t1, input int t2);
    desc_t d;
    d.v0 = v0; d.v1 = v1; d.v2 = v2; d.t1 = t1; d.t2 = t2;
    return d;
  endfunction

  function automatic bit vec_ok(input logic [14:0] v);
    return (v[4:0] <= 5'd4) && (v[9:5] <= 5'd4) && (v[14:10] <= 5'd4);
  endfunction

  function automatic bit desc_ok(input desc_t d);
    return (d.t1 + d.t2 <= HALF) && vec_ok(d.v0) && vec_ok(d.v1) && vec_ok(d.v2);
  endfunction

  // Level wanted at position k (0..PER-1) of a period: mirror k into the half, then pick by dwell.
  function automatic logic [14:0] pat(input desc_t d, input int k);
    int p;
    int t0;
    p  = (k < HALF) ? k : (PER - 1 - k);
    t0 = HALF - d.t1 - d.t2;
    if (p < t0) return d.v0;
    if (p < t0 + d.t1) return d.v1;
    return d.v2;
  endfunction

  function automatic logic [14:0] ramp(input logic [14:0] prev, input logic [14:0] tgt);
`ifdef SVM_SEQ_STEP_LIMIT_EN
    logic [14:0] r;
    for (int ph = 0; ph < 3; ph++) begin
      int a;
      int b;
      a = int'(prev[ph*5 +: 5]);
      b = int'(tgt[ph*5 +: 5]);
      if (b > a) a = a + 1;
      else if (b < a) a = a - 1;
      r[ph*5 +: 5] = 5'(a);
    end
    return r;
`else
    return tgt;
`endif
  endfunction

  function automatic logic [14:0] rnd_vec();
    return lv($urandom_range(0, 4), $urandom_range(0, 4), $urandom_range(0, 4));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_desc(input desc_t d);
    s_vec0  = d.v0;
    s_vec1  = d.v1;
    s_vec2  = d.v2;
    s_t1    = 16'(d.t1);
    s_t2    = 16'(d.t2);
    s_valid = 1'b1;
  endtask

  // Runs n whole periods starting from an observed sync cycle, optionally offering nd at tick send_k.
  task automatic check_period(input int n, input int send_k, input desc_t nd);
    for (int i = 0; i < n * PER; i++) begin
      int k;
      bit full_before;
      bit xfer;
      bit exp_err;
      k           = i % PER;
      full_before = mdl_full;
      if (i == send_k) drive_desc(nd);
      tick();
      s_valid = 1'b0;
      xfer    = (i == send_k) && !full_before;
      exp_err = xfer && !desc_ok(nd);
      if (xfer && desc_ok(nd)) begin
        mdl_full   = 1'b1;
        mdl_shadow = nd;
      end
      mdl_out = ramp(mdl_out, pat(mdl_active, k));
      checks++;
      if ({o_level_c, o_level_b, o_level_a} !== mdl_out)
        $display("FAIL period_level i=%0d k=%0d got=%h exp=%h", i, k, {o_level_c, o_level_b, o_level_a}, mdl_out);
      else passed++;
      checks++;
      if (o_sync !== (k == PER - 1))
        $display("FAIL period_sync i=%0d got=%b exp=%b", i, o_sync, (k == PER - 1));
      else passed++;
      checks++;
      if (o_err !== exp_err)
        $display("FAIL period_err i=%0d got=%b exp=%b", i, o_err, exp_err);
      else passed++;
      if (k == PER - 1 && full_before) begin
        mdl_active = mdl_shadow;
        mdl_full   = 1'b0;
      end
      checks++;
      if (s_ready !== !mdl_full)
        $display("FAIL period_ready i=%0d got=%b exp=%b", i, s_ready, !mdl_full);
      else passed++;
    end
  endtask

  task automatic test_reset();
    tick();
    tick();
    for (int r = 0; r < 2; r++) begin
      checks++;
      if ({o_level_c, o_level_b, o_level_a} !== 15'd0)
        $display("FAIL reset_levels r=%0d got=%h exp=0", r, {o_level_c, o_level_b, o_level_a});
      else passed++;
      checks++;
      if ({o_sync, o_err} !== 2'b00) $display("FAIL reset_pulses r=%0d got=%b exp=00", r, {o_sync, o_err});
      else passed++;
      checks++;
      if (s_ready !== 1'b1) $display("FAIL reset_ready r=%0d got=%b exp=1", r, s_ready);
      else passed++;
      rst_n = 1'b1;
      tick();
    end
    mdl_out = '0;
  endtask

  task automatic test_basic();
    desc_t d;
    d = mk(lv(0, 0, 0), lv(0, 0, 1), lv(0, 1, 1), 3, 2);
    drive_desc(d);
    tick();
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0) $display("FAIL basic_ready_full got=%b exp=0", s_ready);
    else passed++;
    i_enable = 1'b1;
    tick();
    checks++;
    if (o_sync !== 1'b1) $display("FAIL basic_first_sync got=%b exp=1", o_sync);
    else passed++;
    checks++;
    if (s_ready !== 1'b1) $display("FAIL basic_ready_after_sync got=%b exp=1", s_ready);
    else passed++;
    mdl_active = d;
    mdl_full   = 1'b0;
    mdl_out    = ramp(mdl_out, 15'd0);
    check_period(2, -1, d);
  endtask

  task automatic test_reject();
    check_period(1, 3, mk(lv(1, 1, 1), lv(2, 2, 2), lv(3, 3, 3), 6, 5));
    check_period(1, 5, mk(lv(1, 1, 1), lv(0, 5, 1), lv(3, 3, 3), 2, 2));
    check_period(1, 7, mk(lv(1, 1, 1), lv(2, 2, 2), lv(3, 3, 3), 65535, 2));
  endtask

  task automatic test_double_buffer();
    check_period(2, 8, mk(lv(2, 3, 4), lv(4, 4, 4), lv(1, 0, 2), 4, 6));
    check_period(2, 15, mk(lv(3, 2, 1), lv(4, 4, 4), lv(4, 4, 4), 0, 0));
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      desc_t d;
      int    sel;
      d   = mk(rnd_vec(), rnd_vec(), rnd_vec(), 0, 0);
      d.t1 = $urandom_range(0, HALF);
      d.t2 = $urandom_range(0, HALF - d.t1);
      sel = $urandom_range(0, 3);
      if (sel == 0) d.t2 = HALF + 1 - d.t1 + $urandom_range(0, 5);
      else if (sel == 1) d.v2 = lv(0, $urandom_range(5, 31), 0);
      check_period(1, $urandom_range(0, PER - 2), d);
    end
  endtask

  task automatic test_enable_drop();
    for (int k = 0; k < 7; k++) begin
      tick();
      mdl_out = ramp(mdl_out, pat(mdl_active, k));
      checks++;
      if ({o_level_c, o_level_b, o_level_a} !== mdl_out)
        $display("FAIL drop_pre k=%0d got=%h exp=%h", k, {o_level_c, o_level_b, o_level_a}, mdl_out);
      else passed++;
    end
    i_enable = 1'b0;
    for (int j = 0; j < 7; j++) begin
      tick();
      mdl_out = ramp(mdl_out, 15'd0);
      checks++;
      if ({o_sync, o_level_c, o_level_b, o_level_a} !== {1'b0, mdl_out})
        $display("FAIL drop_idle j=%0d got=%h exp=%h", j, {o_sync, o_level_c, o_level_b, o_level_a}, {1'b0, mdl_out});
      else passed++;
    end
    i_enable = 1'b1;
    tick();
    mdl_out = ramp(mdl_out, 15'd0);
    checks++;
    if (o_sync !== 1'b1) $display("FAIL drop_restart_sync got=%b exp=1", o_sync);
    else passed++;
    check_period(1, -1, mdl_active);
    i_enable = 1'b0;
    for (int j = 0; j < 6; j++) begin
      tick();
      mdl_out = ramp(mdl_out, 15'd0);
      checks++;
      if ({o_level_c, o_level_b, o_level_a} !== mdl_out)
        $display("FAIL drop_final j=%0d got=%h exp=%h", j, {o_level_c, o_level_b, o_level_a}, mdl_out);
      else passed++;
    end
  endtask

  task automatic test_step_limit();
    checks++;
    if (s_ready !== 1'b1) $display("FAIL step_ready got=%b exp=1", s_ready);
    else passed++;
    drive_desc(mk(lv(0, 0, 0), lv(0, 0, 4), lv(0, 0, 4), 5, 0));
    tick();
    s_valid  = 1'b0;
    i_enable = 1'b1;
    tick();
    checks++;
    if (o_sync !== 1'b1) $display("FAIL step_sync got=%b exp=1", o_sync);
    else passed++;
    for (int k = 0; k < PER; k++) begin
      int exp_a;
      tick();
`ifdef SVM_SEQ_STEP_LIMIT_EN
      if (k < 5) exp_a = 0;
      else if (k <= 8) exp_a = k - 4;
      else if (k <= 14) exp_a = 4;
      else exp_a = (18 - k > 0) ? 18 - k : 0;
`else
      exp_a = (k >= 5 && k <= 14) ? 4 : 0;
`endif
      checks++;
      if (o_level_a !== 5'(exp_a)) $display("FAIL step_a k=%0d got=%0d exp=%0d", k, o_level_a, exp_a);
      else passed++;
    end
  endtask

  task automatic test_reset_mid();
    for (int j = 0; j < 4; j++) tick();
    drive_desc(mk(lv(1, 1, 1), lv(2, 2, 2), lv(3, 3, 3), 2, 2));
    tick();
    s_valid = 1'b0;
    checks++;
    if (s_ready !== 1'b0) $display("FAIL mid_ready_before got=%b exp=0", s_ready);
    else passed++;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({o_level_c, o_level_b, o_level_a, o_sync, o_err, s_ready} !== 18'd1)
      $display("FAIL mid_reset_now got=%h exp=1", {o_level_c, o_level_b, o_level_a, o_sync, o_err, s_ready});
    else passed++;
    tick();
    rst_n = 1'b1;
    for (int j = 0; j < 25; j++) begin
      tick();
      checks++;
      if ({o_level_c, o_level_b, o_level_a, o_sync, s_ready} !== 17'd1)
        $display("FAIL mid_after_reset j=%0d got=%h exp=1", j, {o_level_c, o_level_b, o_level_a, o_sync, s_ready});
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_double_buffer();
    test_random();
    test_enable_drop();
    test_step_limit();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
